// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler with bounded bursts driving a registered valid/ready output stage
module mux4_rr_sched #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] data_d,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, last, win, scan;
    logic [3:0]       bcnt, bcnt_nxt;
    logic             load, grant, cont;
    logic [WIDTH-1:0] win_data;

    // Rotating-priority scan: descending loop so the smallest offset from ptr wins
    always_comb begin
        scan = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[2'(ptr + 2'(i))]) scan = 2'(ptr + 2'(i));
    end

    // Winner choice (burst continuation or scan), ack decode and next state
    always_comb begin
        load      = (state == IDLE) | out_ready;
        grant     = load & (|req);
        cont      = req[last] & (bcnt != 4'd0) & (bcnt < 4'(MAX_BURST));
        win       = cont ? last : scan;
        bcnt_nxt  = cont ? bcnt + 4'd1 : 4'd1;
        state_nxt = load ? (grant ? HOLD : IDLE) : state;
        ack       = (grant & ~rst) ? (4'b0001 << win) : 4'd0;
        win_data  = (win == 2'd0) ? data_a :
                    (win == 2'd1) ? data_b :
                    (win == 2'd2) ? data_c : data_d;
    end

    // Output register and scheduler history; bcnt clears on going idle so bursts never span a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_data <= '0;
            out_src  <= 2'd0;
            ptr      <= 2'd0;
            last     <= 2'd0;
            bcnt     <= 4'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                out_data <= win_data;
                out_src  <= win;
                last     <= win;
                ptr      <= win + 2'd1;
                bcnt     <= bcnt_nxt;
            end else if (load) begin
                bcnt <= 4'd0;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = out_valid;
endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb_mux4_rr_sched: randomized and directed checks of two scheduler instances (MAX_BURST 4 and 1) against a behavioural model
module tb_mux4_rr_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] da = 4'd0, db = 4'd0, dc = 4'd0, dd = 4'd0;
    logic       out_ready = 1'b0;

    logic [3:0] ack4, ack1, data4, data1;
    logic [1:0] src4, src1;
    logic       valid4, valid1, busy4, busy1;

    int vectors = 0;
    int miscompares = 0;

    int         mb[2] = '{4, 1};
    int         m_valid[2], m_src[2], m_ptr[2], m_last[2], m_run[2];
    logic [3:0] m_data[2];

    always #5 clk = ~clk;

    mux4_rr_sched #(.WIDTH(4), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .ack(ack4), .out_data(data4), .out_src(src4), .out_valid(valid4),
        .out_ready(out_ready), .busy(busy4)
    );

    mux4_rr_sched #(.WIDTH(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
        .ack(ack1), .out_data(data1), .out_src(src1), .out_valid(valid1),
        .out_ready(out_ready), .busy(busy1)
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_src[k] = 0; m_ptr[k] = 0;
            m_last[k] = 0; m_run[k] = 0; m_data[k] = 4'd0;
        end
    endfunction

    function automatic bit m_cont(int k);
        return m_run[k] > 0 && req[m_last[k]] && m_run[k] < mb[k];
    endfunction

    function automatic int m_pick(int k);
        if (m_cont(k)) return m_last[k];
        for (int j = 0; j < 4; j++)
            if (req[(m_ptr[k] + j) % 4]) return (m_ptr[k] + j) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] word(int w);
        return w == 0 ? da : w == 1 ? db : w == 2 ? dc : dd;
    endfunction

    function automatic logic [3:0] exp_ack(int k);
        int w;
        w = m_pick(k);
        if (rst || w < 0 || !(m_valid[k] == 0 || out_ready)) return 4'd0;
        return 4'b0001 << w;
    endfunction

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input logic rdy);
        @(negedge clk);
        rst = r; req = rq; da = a; db = b; dc = c; dd = d; out_ready = rdy;
        if (r) model_reset();
        #1;
    endtask

    task automatic tick();
        int  w[2];
        bit  ld[2], c[2];
        for (int k = 0; k < 2; k++) begin
            ld[k] = m_valid[k] == 0 || out_ready;
            c[k]  = m_cont(k);
            w[k]  = m_pick(k);
        end
        @(posedge clk);
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) begin
            if (ld[k] && w[k] >= 0) begin
                m_valid[k] = 1; m_data[k] = word(w[k]); m_src[k] = w[k];
                m_run[k] = c[k] ? m_run[k] + 1 : 1;
                m_last[k] = w[k]; m_ptr[k] = (w[k] + 1) % 4;
            end else if (ld[k]) begin
                m_valid[k] = 0; m_run[k] = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'hF, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            vectors++;
            if (ack4 !== 4'd0 || ack1 !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_ack: got %h/%h want 0", ack4, ack1);
            end
            tick();
            vectors++;
            if (valid4 !== 1'b0 || data4 !== 4'd0 || src4 !== 2'd0 || busy4 !== 1'b0 || valid1 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out: valid=%b data=%h src=%0d busy=%b want 0", valid4, data4, src4, busy4);
            end
        end
        drive(1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        vectors++;
        if (ack4 !== 4'b0001 || ack1 !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b/%b want 0001", ack4, ack1);
        end
        tick();
    endtask

    task automatic test_single();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b0100, 4'($urandom), 4'($urandom), 4'h9, 4'($urandom), 1'b1);
            vectors++;
            if (ack4 !== 4'b0100 || ack1 !== 4'b0100) begin
                miscompares++;
                $display("FAIL single_ack: got %b/%b want 0100", ack4, ack1);
            end
            tick();
            vectors++;
            if (valid4 !== 1'b1 || data4 !== 4'h9 || src4 !== 2'd2 || busy4 !== 1'b1) begin
                miscompares++;
                $display("FAIL single_out: valid=%b data=%h src=%0d want 1/9/2", valid4, data4, src4);
            end
        end
    endtask

    task automatic test_rr();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
            vectors++;
            if (ack1 !== (4'b0001 << seq[i]) || ack1 !== exp_ack(1)) begin
                miscompares++;
                $display("FAIL rr_ack[%0d]: got %b want %b", i, ack1, 4'b0001 << seq[i]);
            end
            tick();
            vectors++;
            if (src1 !== 2'(seq[i]) || data1 !== 4'(seq[i] + 1)) begin
                miscompares++;
                $display("FAIL rr_src[%0d]: got src=%0d data=%h want %0d", i, src1, data1, seq[i]);
            end
        end
    endtask

    task automatic test_burst();
        int seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'b0011, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
            vectors++;
            if (ack4 !== (4'b0001 << seq[i])) begin
                miscompares++;
                $display("FAIL burst_ack[%0d]: got %b want %b", i, ack4, 4'b0001 << seq[i]);
            end
            tick();
            vectors++;
            if (src4 !== 2'(seq[i]) || valid4 !== 1'b1) begin
                miscompares++;
                $display("FAIL burst_src[%0d]: got %0d want %0d", i, src4, seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] w;
        do_reset();
        drive(1'b0, 4'b0001, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            vectors++;
            if (ack4 !== 4'd0 || ack1 !== 4'd0) begin
                miscompares++;
                $display("FAIL bp_ack[%0d]: got %b/%b want 0", i, ack4, ack1);
            end
            tick();
            vectors++;
            if (data4 !== 4'h5 || src4 !== 2'd0 || valid4 !== 1'b1 || data1 !== 4'h5 || valid1 !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got data=%h src=%0d valid=%b want 5/0/1", i, data4, src4, valid4);
            end
        end
        drive(1'b0, 4'b1000 | 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        w = exp_ack(0);
        vectors++;
        if (ack4 !== w || $countones(ack4) != 1) begin
            miscompares++;
            $display("FAIL bp_release_ack: got %b want %b", ack4, w);
        end
        tick();
        vectors++;
        if (valid4 !== 1'b1 || src4 !== 2'(m_src[0]) || data4 !== m_data[0]) begin
            miscompares++;
            $display("FAIL bp_release_out: got src=%0d data=%h want %0d/%h", src4, data4, m_src[0], m_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0010, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
            tick();
        end
        drive(1'b1, 4'b0110, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        vectors++;
        if (valid4 !== 1'b0 || ack4 !== 4'd0 || data4 !== 4'd0) begin
            miscompares++;
            $display("FAIL midrst_drop: got valid=%b ack=%b data=%h want 0", valid4, ack4, data4);
        end
        tick();
        drive(1'b0, 4'b0110, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        vectors++;
        if (ack4 !== 4'b0010 || ack1 !== 4'b0010) begin
            miscompares++;
            $display("FAIL midrst_first: got %b/%b want 0010", ack4, ack1);
        end
        tick();
        drive(1'b0, 4'b0110, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        vectors++;
        if (ack4 !== 4'b0010 || ack1 !== 4'b0100) begin
            miscompares++;
            $display("FAIL midrst_second: got %b/%b want 0010/0100", ack4, ack1);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] e4, e1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 64) == 0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom % 4) != 0);
            e4 = exp_ack(0);
            e1 = exp_ack(1);
            vectors++;
            if (ack4 !== e4 || ack1 !== e1) begin
                miscompares++;
                $display("FAIL rand_ack[%0d]: got %b/%b want %b/%b", i, ack4, ack1, e4, e1);
            end
            tick();
            vectors++;
            if (valid4 !== 1'(m_valid[0]) || busy4 !== 1'(m_valid[0]) || data4 !== m_data[0] || src4 !== 2'(m_src[0])) begin
                miscompares++;
                $display("FAIL rand_out4[%0d]: got v=%b d=%h s=%0d want %0d/%h/%0d", i, valid4, data4, src4,
                         m_valid[0], m_data[0], m_src[0]);
            end
            vectors++;
            if (valid1 !== 1'(m_valid[1]) || busy1 !== 1'(m_valid[1]) || data1 !== m_data[1] || src1 !== 2'(m_src[1])) begin
                miscompares++;
                $display("FAIL rand_out1[%0d]: got v=%b d=%h s=%0d want %0d/%h/%0d", i, valid1, data1, src1,
                         m_valid[1], m_data[1], m_src[1]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rr();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
